// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared load/store definitions. It holds the funct3 load/store
//               encodings, the load FSM state type and the alignment helper
//               functions.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // funct3 encodings. SB/SH/SW share the low two bits with LB/LH/LW.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Load FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_REQ2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5,
    ST_FAULT = 3'd6
  } load_state_t;

  // Encodings 011, 110 and 111 are not loads.
  function automatic logic is_illegal(input logic [2:0] f3);
    return !((f3 == LB) || (f3 == LH) || (f3 == LW) ||
             (f3 == LBU) || (f3 == LHU));
  endfunction

  // A halfword at an odd offset, or a word at any non-zero offset.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    return (((f3 == LH) || (f3 == LHU)) && off[0]) ||
           ((f3 == LW) && (off != 2'b00));
  endfunction

  // A misaligned access that crosses into the next word needs a second read.
  function automatic logic is_split(input logic [2:0] f3,
                                    input logic [1:0] off);
    return (((f3 == LH) || (f3 == LHU)) && (off == 2'b11)) ||
           ((f3 == LW) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational lane extraction and sign/zero extension. It
//               shifts {word1, word0} right by offset bytes, then extends the
//               selected byte, halfword or word according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] w_low;

  // Only the low 32 bits of the shifted pair can ever be selected.
  assign w_low = 32'({word1_i, word0_i} >> {offset_i, 3'b000});

  // Pick the lane width and extend it.
  always_comb begin
    result_o = 32'd0;
    case (funct3_i)
      LB:      result_o = {{24{w_low[7]}},  w_low[7:0]};
      LH:      result_o = {{16{w_low[15]}}, w_low[15:0]};
      LW:      result_o = w_low;
      LBU:     result_o = {24'd0, w_low[7:0]};
      LHU:     result_o = {16'd0, w_low[15:0]};
      default: result_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Sequential load path of the memory stage. It issues
//               word-aligned reads over a req/gnt/rvalid handshake, then
//               returns the extended result with a one-cycle valid pulse.
//               Illegal funct3 values, and misaligned accesses when
//               unsupported, produce a one-cycle fault pulse instead.
// Config      : LOAD_MISALIGNED_EN - serve misaligned halfword/word loads,
//               using a second read (REQ2/WAIT2) when the access crosses a
//               word boundary. When this macro is undefined, a misaligned
//               access faults.
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        load_fault,
  output logic        busy
);

  load_state_t state_q, state_d;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [29:0] waddr_q;
  logic [31:0] word0_q, word0_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] w_word0, w_word1, w_result;
  logic        w_accept;

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign load_valid = (state_q == ST_RESP);
  assign load_fault = (state_q == ST_FAULT);
  assign load_data  = load_data_q;
  assign w_accept   = req_valid && req_ready;

  // Read request and address. The address is zero whenever no read is pending.
  always_comb begin
    mem_read = 1'b0;
    mem_addr = 32'd0;
    case (state_q)
      ST_REQ: begin
        mem_read = 1'b1;
        mem_addr = {waddr_q, 2'b00};
      end
`ifdef LOAD_MISALIGNED_EN
      ST_REQ2: begin
        mem_read = 1'b1;
        mem_addr = {waddr_q + 30'd1, 2'b00};
      end
`endif
      default: begin
        mem_read = 1'b0;
        mem_addr = 32'd0;
      end
    endcase
  end

  // The result is registered on the same edge that the last word arrives, so
  // the data beat on the bus feeds the aligner directly.
  assign w_word0 = (state_q == ST_WAIT) ? mem_rdata : word0_q;
`ifdef LOAD_MISALIGNED_EN
  assign w_word1 = (state_q == ST_WAIT2) ? mem_rdata : 32'd0;
`else
  assign w_word1 = 32'd0;
`endif

  load_align u_align (
    .word0_i  (w_word0),
    .word1_i  (w_word1),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .result_o (w_result)
  );

  // Next-state logic: acceptance routing and handshake sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_illegal(funct3)) begin
            state_d = ST_FAULT;
`ifndef LOAD_MISALIGNED_EN
          end else if (is_misaligned(funct3, address[1:0])) begin
            state_d = ST_FAULT;
`endif
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
`ifdef LOAD_MISALIGNED_EN
          state_d = is_split(funct3_q, offset_q) ? ST_REQ2 : ST_RESP;
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef LOAD_MISALIGNED_EN
      ST_REQ2: begin
        if (mem_gnt) state_d = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (mem_rvalid) state_d = ST_RESP;
      end
`endif
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First data word is kept while the second read is in flight.
  assign word0_d = ((state_q == ST_WAIT) && mem_rvalid) ? mem_rdata : word0_q;

  // Result only changes when a load completes; faults leave it untouched.
  assign load_data_d = (state_d == ST_RESP) ? w_result : load_data_q;

  // State and datapath registers; reset drops any in-flight load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      waddr_q     <= 30'd0;
      word0_q     <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      word0_q     <= word0_d;
      load_data_q <= load_data_d;
      if (w_accept) begin
        funct3_q <= funct3;
        offset_q <= address[1:0];
        waddr_q  <= address[31:2];
      end
    end
  end

endmodule
`default_nettype wire
